// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one byte-wide UART transmitter between two requesters:
//   - switch reports: a rising edge on the asynchronous ready_sw button
//     captures the 8 switches and queues a report;
//   - RX echoes: every byte received (rx_valid pulse) is queued for echo.
// Each granted request is sent as a two-byte message: a source header
// (HDR_SW or HDR_RX) followed by the payload byte. When both sources are
// waiting, grants alternate (round-robin); after reset the switch path wins
// the first tie.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   ready_sw       asynchronous button; rising edge requests a switch report
//   sw[7:0]        switch values, captured on the synchronized ready_sw edge
//   rx_valid       one-cycle pulse, rx_data[7:0] valid in the same cycle
//   tx_busy        UART busy; high from at most one cycle after tx_start
//                  until the stop bit completes
//   tx_start       one-cycle pulse: transmit tx_data[7:0]
//   tx_data[7:0]   byte to transmit; holds its last value between starts
//   sw_pending     a switch report is queued but not yet granted
//   rx_pending     an RX echo is queued but not yet granted
//   overrun        sticky: an RX byte was dropped (cleared only by reset)
//   fsm_state[2:0] current message FSM state, for observation only
//
// Transmit handshake: the scheduler raises tx_start for exactly one cycle
// with tx_data valid in that cycle, and only when it has seen tx_busy=0.
// The UART may take up to one cycle to raise tx_busy, so the cycle after
// tx_start ignores tx_busy; the next byte is started only after tx_busy has
// been observed low again.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter logic [7:0] HDR_SW = 8'h53,
    parameter logic [7:0] HDR_RX = 8'h52
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ready_sw,
    input  logic [7:0] sw,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       sw_pending,
    output logic       rx_pending,
    output logic       overrun,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        HDR_GAP  = 3'd2,
        HDR_WAIT = 3'd3,
        PAY      = 3'd4,
        PAY_GAP  = 3'd5,
        PAY_WAIT = 3'd6
    } state_t;

    state_t     state;
    state_t     state_next;

    // ready_sw: two flops for metastability, third flop for edge detection
    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic       sw_edge;

    logic [7:0] sw_buf;
    logic [7:0] rx_buf;
    logic [7:0] msg_pay;
    logic       last_grant_rx;   // 1 = last grant went to RX
    logic       grant_sw;
    logic       grant_rx;

    assign sw_edge   = sync2 & ~sync3;
    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state, grant decision and tx_start
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        grant_sw   = 1'b0;
        grant_rx   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && (sw_pending || rx_pending)) begin
                    // SW wins when alone, or on a tie when RX was served last
                    if (sw_pending && (!rx_pending || last_grant_rx)) begin
                        grant_sw = 1'b1;
                    end else begin
                        grant_rx = 1'b1;
                    end
                    state_next = HDR;
                end
            end
            HDR: begin
                tx_start   = 1'b1;
                state_next = HDR_GAP;
            end
            HDR_GAP: begin
                // tx_busy may not have risen yet; ignore it this cycle
                state_next = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (!tx_busy) begin
                    state_next = PAY;
                end
            end
            PAY: begin
                tx_start   = 1'b1;
                state_next = PAY_GAP;
            end
            PAY_GAP: begin
                state_next = PAY_WAIT;
            end
            PAY_WAIT: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture, message buffers and transmit data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync3         <= 1'b0;
            sw_buf        <= 8'h00;
            sw_pending    <= 1'b0;
            rx_buf        <= 8'h00;
            rx_pending    <= 1'b0;
            overrun       <= 1'b0;
            msg_pay       <= 8'h00;
            tx_data       <= 8'h00;
            last_grant_rx <= 1'b1;
        end else begin
            sync1 <= ready_sw;
            sync2 <= sync1;
            sync3 <= sync2;

            // A newer switch edge simply replaces the queued report. A grant in
            // the same cycle takes the old sw_buf; the new report stays queued.
            if (sw_edge) begin
                sw_buf     <= sw;
                sw_pending <= 1'b1;
            end else if (grant_sw) begin
                sw_pending <= 1'b0;
            end

            // RX keeps the oldest byte; a byte arriving while one is queued is
            // dropped unless the queued one is being granted this very cycle.
            if (rx_valid) begin
                if (!rx_pending || grant_rx) begin
                    rx_buf     <= rx_data;
                    rx_pending <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (grant_rx) begin
                rx_pending <= 1'b0;
            end

            // tx_data is loaded one cycle ahead of each tx_start and then held
            if (grant_sw) begin
                tx_data       <= HDR_SW;
                msg_pay       <= sw_buf;
                last_grant_rx <= 1'b0;
            end else if (grant_rx) begin
                tx_data       <= HDR_RX;
                msg_pay       <= rx_buf;
                last_grant_rx <= 1'b1;
            end else if (state == HDR_WAIT && !tx_busy) begin
                tx_data <= msg_pay;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Drives uart_tx_scheduler against a simple UART model that holds tx_busy
// for 10 cycles per started byte and logs every started byte. A message-level
// reference model (queued sources, round-robin memory, overrun flag) builds
// the expected byte stream, which is compared with the logged stream once the
// link goes quiet. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ready_sw = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       sw_pending;
    logic       rx_pending;
    logic       overrun;
    logic [2:0] fsm_state;

    uart_tx_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_sw   (ready_sw),
        .sw         (sw),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .sw_pending (sw_pending),
        .rx_pending (rx_pending),
        .overrun    (overrun),
        .fsm_state  (fsm_state)
    );

    // ---------------- UART model and byte logger ----------------
    int         busy_cnt = 0;
    logic       prev_start = 1'b0;
    int         viol = 0;
    logic [7:0] act_q[$];

    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            act_q.push_back(tx_data);
            busy_cnt <= 10;
            if (prev_start || tx_busy) viol <= viol + 1;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        prev_start <= tx_start;
    end

    // ---------------- scoreboard / reference model ----------------
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         m_last_rx = 1'b1;
    bit         m_overrun = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_msg(input bit src_rx, input logic [7:0] d);
        exp_q.push_back(src_rx ? 8'h52 : 8'h53);
        exp_q.push_back(d);
        m_last_rx = src_rx;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    // Switch edge and RX byte land in the same capture cycle
    task automatic both_req(input logic [7:0] s, input logic [7:0] r, input string tag);
        sw       = s;
        ready_sw = 1'b1;
        step();
        step();
        rx_data  = r;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        @(negedge clk);
        check({tag, "_both_pending"}, {sw_pending, rx_pending}, 2'b11);
        step();
        ready_sw = 1'b0;
        if (m_last_rx) begin
            push_msg(1'b0, s);
            push_msg(1'b1, r);
        end else begin
            push_msg(1'b1, r);
            push_msg(1'b0, s);
        end
    endtask

    // Switch report, then k RX bytes while that message is on the wire
    task automatic sw_with_rx(input logic [7:0] s, input int k,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        sw       = s;
        ready_sw = 1'b1;
        repeat (3) step();
        ready_sw = 1'b0;
        repeat (4) step();
        if (k >= 1) rx_pulse(d0);
        step();
        if (k >= 2) rx_pulse(d1);
        step();
        if (k >= 3) rx_pulse(d2);
        push_msg(1'b0, s);
        if (k >= 1) push_msg(1'b1, d0);
        if (k >= 2) m_overrun = 1'b1;
    endtask

    // Wait for the expected bytes and an idle link, then compare streams
    task automatic drain(input string tag);
        int cyc = 0;
        while ((act_q.size() < exp_q.size() || tx_busy) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (30) @(negedge clk);
        check({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) check($sformatf("%s_byte%0d", tag, i), act_q[i], exp_q[i]);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat;
        int cyc;

        // Reset held 3 cycles with activity on the inputs
        for (int i = 0; i < 3; i++) begin
            ready_sw = ~ready_sw;
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
            @(negedge clk);
            check($sformatf("reset_outputs_%0d", i),
                  {tx_start, tx_data, sw_pending, rx_pending, overrun}, 12'h000);
            step();
            rx_valid = 1'b0;
        end
        ready_sw = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("reset_no_tx", act_q.size(), 0);
        check("reset_idle_state", fsm_state, 3'd0);

        // Round-robin: SW wins the first tie, RX the next
        both_req(8'h0F, 8'hF0, "rr1");
        drain("rr1");
        both_req(8'h0F, 8'hF0, "rr2");
        drain("rr2");

        // Single RX echo with latency checks
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        @(negedge clk);
        check("rx_pending_set", rx_pending, 1'b1);
        check("rx_no_early_start", tx_start, 1'b0);
        step();
        @(negedge clk);
        check("rx_hdr_start", tx_start, 1'b1);
        check("rx_hdr_data", tx_data, 8'h52);
        push_msg(1'b1, 8'hA5);
        drain("rx_single");
        check("rx_pending_clear", rx_pending, 1'b0);

        // Switch report held high for 20 cycles: exactly one message
        sw       = 8'h3C;
        ready_sw = 1'b1;
        lat      = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (tx_start) break;
        end
        check("sw_latency_le5", (lat <= 5), 1'b1);
        repeat (20 - lat) @(negedge clk);
        step();
        ready_sw = 1'b0;
        push_msg(1'b0, 8'h3C);
        drain("sw_held");
        sw       = 8'hC3;
        ready_sw = 1'b1;
        repeat (3) step();
        ready_sw = 1'b0;
        push_msg(1'b0, 8'hC3);
        drain("sw_second");

        // Overrun: 11 queued, 22 and 33 dropped
        check("overrun_initially_clear", overrun, 1'b0);
        sw_with_rx(8'h5A, 3, 8'h11, 8'h22, 8'h33);
        drain("overrun_msgs");
        check("overrun_set", overrun, 1'b1);
        repeat (20) step();
        check("overrun_sticky", overrun, 1'b1);

        // Reset while waiting for the header to finish
        rx_pulse(8'h77);
        cyc = 0;
        while (fsm_state != 3'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reached_hdr_wait", fsm_state, 3'd3);
        step();
        rx_pulse(8'h88);
        @(negedge clk);
        check("mid_rx_queued", rx_pending, 1'b1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_flags", {sw_pending, rx_pending, overrun, tx_start}, 4'b0000);
        check("mid_reset_state", fsm_state, 3'd0);
        step();
        rst_n = 1'b1;
        m_last_rx = 1'b1;
        m_overrun = 1'b0;
        repeat (40) step();
        check("mid_only_header_sent", act_q.size(), 1);
        if (act_q.size() > 0) check("mid_header_byte", act_q[0], 8'h52);
        act_q.delete();

        // Randomized rounds against the message-level model
        for (int r = 0; r < 10; r++) begin
            int         kind;
            logic [7:0] a;
            logic [7:0] b;
            kind = $urandom_range(0, 2);
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                rx_pulse(a);
                push_msg(1'b1, a);
            end else if (kind == 1) begin
                sw_with_rx(a, $urandom_range(0, 3), b, 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)));
            end else begin
                both_req(a, b, $sformatf("rnd%0d", r));
            end
            drain($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_overrun", r), overrun, m_overrun);
            check($sformatf("rnd%0d_pending", r), {sw_pending, rx_pending}, 2'b00);
        end

        check("tx_start_protocol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
